// File: rtl/voice_sched_pkg.sv
// Shared state encoding, widths and mix saturation for the voice scheduler slice.
package voice_sched_pkg;

  typedef enum logic [1:0] {
    ST_READ    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UPDATE  = 2'd2,
    ST_IDLE    = 2'd3
  } pipe_state_e;

  localparam int WT_PHASE_W = 10;
  localparam int WAVE_W     = 4;
  localparam int SAMPLE_W   = 16;
  localparam int MIX_ACC_W  = 24;

  localparam logic signed [MIX_ACC_W-1:0] MIX_MAX = MIX_ACC_W'(32767);
  localparam logic signed [MIX_ACC_W-1:0] MIX_MIN = MIX_ACC_W'(-32768);

  // Wide accumulator can hold 256 full-scale voices; only the output is clamped.
  function automatic logic signed [SAMPLE_W-1:0] clamp_mix(input logic signed [MIX_ACC_W-1:0] acc);
    if (acc > MIX_MAX)
      return SAMPLE_W'(32767);
    else if (acc < MIX_MIN)
      return SAMPLE_W'(-32768);
    else
      return acc[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/voice_param_regs.sv
// Per-voice delta, phase, wave and gate storage with one read port,
// a phase write-back port and a parameter write port.
module voice_param_regs
  import voice_sched_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int PHASE_W    = 24
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         rd_voice,
  output logic [PHASE_W-1:0] rd_delta,
  output logic [PHASE_W-1:0] rd_phase,
  output logic [WAVE_W-1:0]  rd_wave,
  output logic               rd_gate,
  input  logic               ph_we,
  input  logic [7:0]         ph_voice,
  input  logic [PHASE_W-1:0] ph_data,
  input  logic               wr_en,
  input  logic [7:0]         wr_voice,
  input  logic [PHASE_W-1:0] wr_delta,
  input  logic [WAVE_W-1:0]  wr_wave,
  input  logic               wr_gate
);

  logic [PHASE_W-1:0] delta_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [WAVE_W-1:0]  wave_q  [NUM_VOICES];
  logic               gate_q  [NUM_VOICES];

  always_comb begin
    rd_delta = '0;
    rd_phase = '0;
    rd_wave  = '0;
    rd_gate  = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rd_voice == 8'(v)) begin
        rd_delta = delta_q[v];
        rd_phase = phase_q[v];
        rd_wave  = wave_q[v];
        rd_gate  = gate_q[v];
      end
    end
  end

  // Out-of-range write indices match no voice, so such writes vanish here.
  // A gate-off write zeroes the phase and wins over a same-cycle write-back.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        delta_q[v] <= '0;
        phase_q[v] <= '0;
        wave_q[v]  <= '0;
        gate_q[v]  <= 1'b0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (ph_we && ph_voice == 8'(v))
          phase_q[v] <= ph_data;
        if (wr_en && wr_voice == 8'(v)) begin
          delta_q[v] <= wr_delta;
          wave_q[v]  <= wr_wave;
          gate_q[v]  <= wr_gate;
          if (gate_q[v] && !wr_gate)
            phase_q[v] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Sweeps every voice through the wavetable's read/compute/update pipeline on each
// sample tick, advances phases, and sums the returned samples into a saturated mix.
module voice_scheduler
  import voice_sched_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int PHASE_W    = 24
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_sample_tick,
  output logic [7:0]                 o_voice_index,
  output logic [1:0]                 o_pipeline_state,
  output logic [WT_PHASE_W-1:0]      o_phase,
  output logic [WAVE_W-1:0]          o_wave_select,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic                       i_upd_valid,
  output logic                       o_upd_ready,
  input  logic [7:0]                 i_upd_voice,
  input  logic [PHASE_W-1:0]         i_upd_delta,
  input  logic [WAVE_W-1:0]          i_upd_wave,
  input  logic                       i_upd_gate,
  output logic signed [SAMPLE_W-1:0] o_mix,
  output logic                       o_mix_valid,
  output logic                       o_busy,
  output logic                       o_overrun
);

  pipe_state_e                  state_q, state_d;
  logic [7:0]                   voice_q;
  logic                         pending_q, overrun_q, mix_valid_q;
  logic signed [MIX_ACC_W-1:0]  acc_q, acc_sum, sample_term;
  logic signed [SAMPLE_W-1:0]   mix_q;
  logic                         last_voice, start_sweep, in_update, upd_fire;
  logic [PHASE_W-1:0]           rd_delta, rd_phase, ph_data;
  logic [WAVE_W-1:0]            rd_wave;
  logic                         rd_gate;

  assign last_voice  = (voice_q == 8'(NUM_VOICES - 1));
  assign start_sweep = (state_q == ST_IDLE) && (pending_q || i_sample_tick);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_sweep) state_d = ST_READ;
      ST_READ:    state_d = ST_COMPUTE;
      ST_COMPUTE: state_d = ST_UPDATE;
      ST_UPDATE:  state_d = last_voice ? ST_IDLE : ST_READ;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Ready comes from registered state only, so it never depends on i_upd_valid.
  always_comb begin
    o_busy      = (state_q != ST_IDLE);
    o_upd_ready = (state_q == ST_IDLE) || (state_q == ST_UPDATE);
    in_update   = (state_q == ST_UPDATE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      voice_q <= '0;
    else if (in_update)
      voice_q <= last_voice ? 8'd0 : voice_q + 8'd1;
  end

  // A tick landing on the cycle that consumes the pending flag re-arms it without overrun.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (start_sweep) begin
      pending_q <= pending_q && i_sample_tick;
    end else if (i_sample_tick) begin
      pending_q <= 1'b1;
      if (pending_q)
        overrun_q <= 1'b1;
    end
  end

  assign sample_term = rd_gate ? MIX_ACC_W'(i_sample) : '0;
  assign acc_sum     = acc_q + sample_term;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      acc_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      mix_valid_q <= 1'b0;
      if (in_update) begin
        if (last_voice) begin
          mix_q       <= clamp_mix(acc_sum);
          mix_valid_q <= 1'b1;
          acc_q       <= '0;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end

  // Phase advance reads the delta register before any same-cycle write lands.
  assign ph_data  = rd_gate ? rd_phase + rd_delta : '0;
  assign upd_fire = i_upd_valid && o_upd_ready;

  voice_param_regs #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W)
  ) u_regs (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .rd_voice (voice_q),
    .rd_delta (rd_delta),
    .rd_phase (rd_phase),
    .rd_wave  (rd_wave),
    .rd_gate  (rd_gate),
    .ph_we    (in_update),
    .ph_voice (voice_q),
    .ph_data  (ph_data),
    .wr_en    (upd_fire),
    .wr_voice (i_upd_voice),
    .wr_delta (i_upd_delta),
    .wr_wave  (i_upd_wave),
    .wr_gate  (i_upd_gate)
  );

  assign o_voice_index    = voice_q;
  assign o_pipeline_state = state_q;
  assign o_phase          = rd_phase[PHASE_W-1 -: WT_PHASE_W];
  assign o_wave_select    = rd_wave;
  assign o_mix            = mix_q;
  assign o_mix_valid      = mix_valid_q;
  assign o_overrun        = overrun_q;

endmodule
